// File: rtl/arcade_pkg.sv
// Shared definitions for the arcade pause/dim controller.
package arcade_pkg;

    // Bit positions inside the options bus.
    localparam int OPT_OSD = 0;
    localparam int OPT_DIM = 1;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pause_dim_timer.sv
// Idle timer: counts whole seconds while enabled and raises dim_active once
// DIM_SECS seconds have elapsed. Dropping the enable clears everything.
module pause_dim_timer
    import arcade_pkg::*;
#(
    parameter int CLK_HZ   = 12_000_000,
    parameter int DIM_SECS = 10
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic en,
    output logic dim_active
);

    localparam int PW = cnt_w(CLK_HZ);
    localparam int SW = cnt_w(DIM_SECS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SEC_MAX  = SW'(DIM_SECS);

    logic [PW-1:0] pre_cnt;
    logic [SW-1:0] sec_cnt;

    // Prescaler wraps once per second; seconds saturate; dim follows saturation one cycle later.
    always_ff @(posedge clk_sys) begin
        if (reset || !en) begin
            pre_cnt    <= '0;
            sec_cnt    <= '0;
            dim_active <= 1'b0;
        end else begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
                if (sec_cnt != SEC_MAX)
                    sec_cnt <= sec_cnt + SW'(1);
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
            dim_active <= (sec_cnt == SEC_MAX);
        end
    end

endmodule

// File: rtl/arcade_pause_ctrl.sv
// Pause and dim controller: merges user, OSD and system pause requests into
// a registered CPU halt, optionally frame-aligns the local pause, and dims
// the RGB stream after a programmable idle time.
module arcade_pause_ctrl
    import arcade_pkg::*;
#(
    parameter int RW          = 3,
    parameter int GW          = 3,
    parameter int BW          = 2,
    parameter int CLK_HZ      = 12_000_000,
    parameter int NREQ        = 2,
    parameter int DIM_SECS    = 10,
    parameter int DIM_SHIFT   = 1,
    parameter int SYNC_VBLANK = 1
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               user_button,
    input  logic [NREQ-1:0]    pause_request,
    input  logic [1:0]         options,
    input  logic               OSD_STATUS,
    input  logic               vblank,
    input  logic [RW+GW+BW-1:0] rgb_in,
    output logic [RW+GW+BW-1:0] rgb_out,
    output logic               pause_cpu,
    output logic               dim_active
);

    localparam int CW = RW + GW + BW;

    logic btn_q;
    logic user_pause;
    logic loc_req;
    logic loc_eff;
    logic timer_en;
    logic dimmed;

    // Button edge detect; each rising edge flips the user pause state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_q      <= 1'b0;
            user_pause <= 1'b0;
        end else begin
            btn_q <= user_button;
            if (user_button && !btn_q)
                user_pause <= ~user_pause;
        end
    end

    assign loc_req = user_pause | (options[OPT_OSD] & OSD_STATUS);

    generate
        if (SYNC_VBLANK != 0) begin : g_sync
            logic vblank_q;
            logic eff_q;

            // Local pause only changes on the vblank rising edge, so a request
            // that comes and goes between two frames is never seen.
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    vblank_q <= 1'b0;
                    eff_q    <= 1'b0;
                end else begin
                    vblank_q <= vblank;
                    if (vblank && !vblank_q)
                        eff_q <= loc_req;
                end
            end

            assign loc_eff = eff_q;
        end else begin : g_imm
            assign loc_eff = loc_req;
        end
    endgenerate

    // System requests bypass frame alignment and act on the next cycle.
    always_ff @(posedge clk_sys) begin
        if (reset)
            pause_cpu <= 1'b0;
        else
            pause_cpu <= loc_eff | (|pause_request);
    end

    // Only a local pause may dim the picture; system requests never do.
    assign timer_en = loc_eff & options[OPT_DIM];

    pause_dim_timer #(
        .CLK_HZ   (CLK_HZ),
        .DIM_SECS (DIM_SECS)
    ) u_timer (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .en         (timer_en),
        .dim_active (dim_active)
    );

    logic [RW-1:0] r_in;
    logic [GW-1:0] g_in;
    logic [BW-1:0] b_in;

    assign r_in = rgb_in[CW-1 -: RW];
    assign g_in = rgb_in[GW+BW-1 -: GW];
    assign b_in = rgb_in[BW-1:0];

    // Gating with reset keeps the picture untouched while reset is held,
    // before the dim register itself has cleared.
    assign dimmed  = dim_active & ~reset;
    assign rgb_out = dimmed ? {r_in >> DIM_SHIFT, g_in >> DIM_SHIFT, b_in >> DIM_SHIFT}
                            : rgb_in;

endmodule

// File: tb/tb_arcade_pause_ctrl.sv
// Bench for arcade_pause_ctrl: one immediate and one vblank-aligned instance
// driven from the same stimulus and compared every cycle against a model.
module tb_arcade_pause_ctrl;

    localparam int T_CLK_HZ   = 10;
    localparam int T_DIM_SECS = 2;
    localparam int DIM_TICKS  = T_CLK_HZ * T_DIM_SECS;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       user_button;
    logic [2:0] pause_request;
    logic [1:0] options;
    logic       OSD_STATUS;
    logic       vblank;
    logic [7:0] rgb_in;
    logic [7:0] rgb_out_imm, rgb_out_syn;
    logic       pause_imm, pause_syn;
    logic       dim_imm, dim_syn;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // model state: index 0 = immediate instance, 1 = vblank-aligned instance
    logic m_btn_prev, m_parity, m_vb_prev, m_eff_syn;
    int   m_run [2];
    logic m_pause [2];
    logic m_dim [2];

    always #5 clk_sys = ~clk_sys;

    arcade_pause_ctrl #(
        .CLK_HZ(T_CLK_HZ), .DIM_SECS(T_DIM_SECS), .NREQ(3), .SYNC_VBLANK(0)
    ) dut_imm (
        .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
        .pause_request(pause_request), .options(options), .OSD_STATUS(OSD_STATUS),
        .vblank(vblank), .rgb_in(rgb_in), .rgb_out(rgb_out_imm),
        .pause_cpu(pause_imm), .dim_active(dim_imm)
    );

    arcade_pause_ctrl #(
        .CLK_HZ(T_CLK_HZ), .DIM_SECS(T_DIM_SECS), .NREQ(3), .SYNC_VBLANK(1)
    ) dut_syn (
        .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
        .pause_request(pause_request), .options(options), .OSD_STATUS(OSD_STATUS),
        .vblank(vblank), .rgb_in(rgb_in), .rgb_out(rgb_out_syn),
        .pause_cpu(pause_syn), .dim_active(dim_syn)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // 3/3/2 channels, each halved
    function automatic logic [7:0] dim_rgb(input logic [7:0] v);
        int r, g, b;
        r = ((v >> 5) & 7) / 2;
        g = ((v >> 2) & 7) / 2;
        b = (v & 3) / 2;
        return 8'(r * 32 + g * 4 + b);
    endfunction

    // Reference behaviour, evaluated with the inputs present at a rising edge.
    task automatic model_step();
        logic loc_req;
        logic eff [2];
        if (reset) begin
            m_btn_prev = 1'b0; m_parity = 1'b0; m_vb_prev = 1'b0; m_eff_syn = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_pause[i] = 1'b0; m_dim[i] = 1'b0;
            end
        end else begin
            loc_req = m_parity | (options[0] & OSD_STATUS);
            eff[0]  = loc_req;
            eff[1]  = m_eff_syn;
            for (int i = 0; i < 2; i++) begin
                m_pause[i] = eff[i] | (pause_request != 3'b000);
                m_run[i]   = (eff[i] & options[1]) ? m_run[i] + 1 : 0;
                m_dim[i]   = (m_run[i] > DIM_TICKS);
            end
            if (vblank && !m_vb_prev) m_eff_syn = loc_req;
            if (user_button && !m_btn_prev) m_parity = ~m_parity;
            m_btn_prev = user_button;
            m_vb_prev  = vblank;
        end
    endtask

    task automatic cycle();
        logic [7:0] exp_rgb [2];
        @(posedge clk_sys);
        model_step();
        #1;
        cyc++;
        for (int i = 0; i < 2; i++)
            exp_rgb[i] = (m_dim[i] && !reset) ? dim_rgb(rgb_in) : rgb_in;
        check_val("pause_imm", 32'(pause_imm), 32'(m_pause[0]));
        check_val("pause_syn", 32'(pause_syn), 32'(m_pause[1]));
        check_val("dim_imm",   32'(dim_imm),   32'(m_dim[0]));
        check_val("dim_syn",   32'(dim_syn),   32'(m_dim[1]));
        check_val("rgb_imm",   32'(rgb_out_imm), 32'(exp_rgb[0]));
        check_val("rgb_syn",   32'(rgb_out_syn), 32'(exp_rgb[1]));
        @(negedge clk_sys);
    endtask

    initial begin
        reset = 1'b1; user_button = 1'b0; pause_request = 3'b000;
        options = 2'b00; OSD_STATUS = 1'b0; vblank = 1'b0;
        rgb_in = 8'($urandom);
        repeat (3) cycle();
        reset = 1'b0;

        // single pulse, then frame edge for the aligned instance
        user_button = 1'b1; cycle();
        user_button = 1'b0; repeat (4) cycle();
        vblank = 1'b1; cycle();
        vblank = 1'b0; repeat (3) cycle();
        // second pulse releases
        user_button = 1'b1; cycle();
        user_button = 1'b0; repeat (3) cycle();
        vblank = 1'b1; cycle();
        vblank = 1'b0; repeat (3) cycle();
        // long hold toggles only once
        user_button = 1'b1; repeat (100) cycle();
        user_button = 1'b0; repeat (2) cycle();
        vblank = 1'b1; cycle();
        vblank = 1'b0; repeat (2) cycle();
        // press and release-press between frames: aligned instance stays put
        user_button = 1'b1; cycle();
        user_button = 1'b0; repeat (5) cycle();
        user_button = 1'b1; cycle();
        user_button = 1'b0; repeat (5) cycle();
        vblank = 1'b1; cycle();
        vblank = 1'b0; repeat (3) cycle();
        // button edge coincident with a frame edge
        user_button = 1'b1; vblank = 1'b1; cycle();
        user_button = 1'b0; vblank = 1'b0; repeat (3) cycle();
        vblank = 1'b1; cycle();
        vblank = 1'b0; repeat (3) cycle();
        // system request only
        pause_request = 3'b100; repeat (5) cycle();
        pause_request = 3'b000; repeat (3) cycle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(9) == 0) user_button = ~user_button;
            if ($urandom_range(5) == 0) vblank = ~vblank;
            if ($urandom_range(29) == 0) OSD_STATUS = ~OSD_STATUS;
            if ($urandom_range(49) == 0) options = 2'($urandom);
            pause_request = ($urandom_range(5) == 0) ? 3'($urandom) : 3'b000;
            reset = ($urandom_range(199) == 0);
            rgb_in = 8'($urandom);
            cycle();
        end

        // dim sequence on a clean start
        reset = 1'b1; user_button = 1'b0; pause_request = 3'b000; vblank = 1'b0;
        cycle();
        reset = 1'b0; options = 2'b11; OSD_STATUS = 1'b1; vblank = 1'b1; rgb_in = 8'hFF;
        cycle();
        vblank = 1'b0;
        repeat (30) cycle();
        check_val("dim_rgb_imm", 32'(rgb_out_imm), 32'h6D);
        check_val("dim_rgb_syn", 32'(rgb_out_syn), 32'h6D);
        options = 2'b01; cycle();
        check_val("undim_imm", 32'(dim_imm), 32'd0);
        options = 2'b11; repeat (30) cycle();
        check_val("redim_syn", 32'(dim_syn), 32'd1);
        rgb_in = 8'($urandom);
        reset = 1'b1; cycle();
        check_val("rst_pause", 32'({pause_imm, pause_syn}), 32'd0);
        check_val("rst_dim",   32'({dim_imm, dim_syn}), 32'd0);
        check_val("rst_rgb",   32'(rgb_out_syn), 32'(rgb_in));
        reset = 1'b0; repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
